// File: rtl/mul_4_bits_pkg.sv
// mul_4_bits_pkg: shared widths and operand/product types for the 4x4 multiplier.
package mul_4_bits_pkg;

   localparam int IN_W  = 4;
   localparam int OUT_W = 8;

   typedef logic [IN_W-1:0]  operand_t;
   typedef logic [OUT_W-1:0] product_t;

endpackage : mul_4_bits_pkg

// File: rtl/mul_4_bits_fa.sv
// mul_4_bits_fa: 1-bit full adder cell of the multiplier array.
// Used as a half adder by tying cin to 0.
module mul_4_bits_fa (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);

   assign s    = a ^ b ^ cin;
   assign cout = (a & b) | (cin & (a ^ b));

endmodule : mul_4_bits_fa

// File: rtl/mul_4_bits.sv
// mul_4_bits: registered 4x4 array multiplier with 8-bit product.
// Partial-product AND plane, ripple-carry full-adder rows, one output register.
// Optional macro MUL_4_BITS_SIGNED_EN selects a two's-complement Baugh-Wooley array;
// the default build multiplies unsigned operands.
module mul_4_bits
   import mul_4_bits_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic [IN_W-1:0]  x,
   input  logic [IN_W-1:0]  y,
   output logic [OUT_W-1:0] out
);

`ifdef MUL_4_BITS_SIGNED_EN
   // Baugh-Wooley: invert the bit-3 cross terms and add 1 at weights 4 and 7.
   localparam logic C_SIGNED = 1'b1;
`else
   localparam logic C_SIGNED = 1'b0;
`endif

   operand_t w_pp [IN_W];
   product_t w_prod;
   product_t r_out;

   // Partial products pp[i][j] = x[j] & y[i], cross terms inverted in signed mode.
   always_comb begin
      // NOTE: every bit of w_pp is written on every evaluation, so no latch is inferred.
      for (int i = 0; i < IN_W; i++) begin
         for (int j = 0; j < IN_W; j++) begin
            w_pp[i][j] = (x[j] & y[i]) ^ (C_SIGNED & ((i == IN_W-1) != (j == IN_W-1)));
         end
      end
   end

   // Row 0 is pp[0] itself; its LSB is product bit 0 and its upper bits feed row 1.
   assign w_prod[0] = w_pp[0][0];

   // Rows 1..3: each adds pp[i] to the running sum shifted down by one position.
   // Running-sum bit j of a row comes from the previous row's sum bit j+1, and the
   // top bit from the previous row's carry out (row 1 takes the weight-4 constant).
   for (genvar i = 1; i < IN_W; i++) begin : g_row
      for (genvar j = 0; j < IN_W; j++) begin : g_col
         logic w_b;
         logic w_cin;
         logic w_s;
         logic w_cout;

         if (i == 1) begin : g_first
            if (j < IN_W-1) begin : g_pp0
               assign w_b = w_pp[0][j+1];
            end else begin : g_k4
               assign w_b = C_SIGNED;
            end
         end else begin : g_later
            if (j < IN_W-1) begin : g_sum
               assign w_b = g_row[i-1].g_col[j+1].w_s;
            end else begin : g_carry
               assign w_b = g_row[i-1].g_col[IN_W-1].w_cout;
            end
         end

         if (j == 0) begin : g_lsb
            assign w_cin = 1'b0;
         end else begin : g_ripple
            assign w_cin = g_col[j-1].w_cout;
         end

         mul_4_bits_fa u_fa (
            .a    (w_pp[i][j]),
            .b    (w_b),
            .cin  (w_cin),
            .s    (w_s),
            .cout (w_cout)
         );

         // The LSB of each row is a finished product bit.
         if (j == 0) begin : g_out_lsb
            assign w_prod[i] = w_s;
         end

         // The last row's sums and carry form product bits 7..4.
         if (i == IN_W-1 && j > 0) begin : g_out_hi
            assign w_prod[IN_W-1+j] = w_s;
         end
         if (i == IN_W-1 && j == IN_W-1) begin : g_out_msb
            assign w_prod[OUT_W-1] = w_cout ^ C_SIGNED;
         end
      end
   end

   // Output register: capture the product every edge, cleared asynchronously by rst.
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: non-blocking assignment so every register samples pre-edge values.
      if (rst) begin
         r_out <= '0;
      end else begin
         r_out <= w_prod;
      end
   end

   assign out = r_out;

endmodule : mul_4_bits

// File: tb/tb_mul_4_bits.sv
// tb_mul_4_bits: directed and exhaustive bench for mul_4_bits with a product scoreboard.
// Honours MUL_4_BITS_SIGNED_EN the same way as the design.
module tb_mul_4_bits;
   import mul_4_bits_pkg::*;

   logic     clk = 1'b0;
   logic     rst;
   operand_t x;
   operand_t y;
   product_t out;

   int       errors = 0;
   int       checks = 0;
   product_t sb [$];
   product_t last_exp;

   always #5 clk = ~clk;

   mul_4_bits dut (
      .clk (clk),
      .rst (rst),
      .x   (x),
      .y   (y),
      .out (out)
   );

   // Reference product, independent of the array structure.
   function automatic product_t ref_mul(input operand_t a, input operand_t b);
      int p;
`ifdef MUL_4_BITS_SIGNED_EN
      p = int'($signed(a)) * int'($signed(b));
`else
      p = int'(a) * int'(b);
`endif
      return product_t'(p);
   endfunction

   task automatic check(input string tag, input product_t obs, input product_t exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=0x%02h expected=0x%02h", tag, obs, exp);
      end
   endtask

   // Apply operands mid-cycle, confirm the old product still holds before the edge,
   // then compare the scoreboard head just after the capturing edge.
   task automatic drive(input operand_t a, input operand_t b, input product_t exp,
                        input string tag);
      @(negedge clk);
      x = a;
      y = b;
      sb.push_back(exp);
      #1 check({tag, "_hold"}, out, last_exp);
      @(posedge clk);
      #1;
      last_exp = sb.pop_front();
      check(tag, out, last_exp);
   endtask

   initial begin
      rst      = 1'b1;
      x        = 4'hF;
      y        = 4'hF;
      last_exp = '0;

      // Reset holds out at zero even with clock running and max operands.
      #1 check("reset_t0", out, 8'h00);
      repeat (3) begin
         @(posedge clk);
         #1 check("reset_hold", out, 8'h00);
      end

      // First edge after release loads x*y.
      @(negedge clk);
      rst = 1'b0;
      sb.push_back(ref_mul(4'hF, 4'hF));
      #1 check("release_pre", out, 8'h00);
      @(posedge clk);
      #1;
      last_exp = sb.pop_front();
      check("release_load", out, last_exp);

`ifdef MUL_4_BITS_SIGNED_EN
      drive(4'hF, 4'h7, 8'hF9, "m1x7");
      drive(4'h8, 4'h7, 8'hC8, "m8x7");
      drive(4'h8, 4'h8, 8'h40, "m8xm8");
      drive(4'h7, 4'h7, 8'h31, "7x7");
      drive(4'h7, 4'h8, 8'hC8, "7xm8");
`else
      drive(4'd0,  4'd13, 8'h00, "0x13");
      drive(4'd1,  4'd9,  8'h09, "1x9");
      drive(4'd15, 4'd15, 8'hE1, "15x15");
      drive(4'd8,  4'd8,  8'h40, "8x8");
      // Back-to-back operands on consecutive cycles.
      drive(4'd7,  4'd9,  8'h3F, "pipe_7x9");
      drive(4'd3,  4'd5,  8'h0F, "pipe_3x5");
      drive(4'd12, 4'd10, 8'h78, "pipe_12x10");
`endif

      // Mid-stream asynchronous reset clears out between edges.
      drive(4'hF, 4'hF, ref_mul(4'hF, 4'hF), "pre_async");
      #2;
      x   = 4'h5;
      y   = 4'h5;
      rst = 1'b1;
      #1 check("async_clear", out, 8'h00);
      @(posedge clk);
      #1 check("async_inflight", out, 8'h00);
      @(negedge clk);
      rst = 1'b0;
      sb.push_back(ref_mul(4'h5, 4'h5));
      @(posedge clk);
      #1;
      last_exp = sb.pop_front();
      check("async_release", out, last_exp);

      // Exhaustive sweep, one new pair per cycle.
      for (int a = 0; a < 16; a++) begin
         for (int b = 0; b < 16; b++) begin
            drive(operand_t'(a), operand_t'(b), ref_mul(operand_t'(a), operand_t'(b)),
                  $sformatf("exh_%0d_%0d", a, b));
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_mul_4_bits
